uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver core.
- Detects end-of-frame from the receiver's busy/data/error outputs and tags each received byte with its parity and framing error status.
- Stores the tagged bytes in a FIFO and presents them to the host logic over a valid/ready stream.
- Tracks overrun and counts errored frames.

Parameters:
- p_depth, 16, FIFO entries; power of two, >= 2.
- p_drop_errored, 0, 1 = errored frames are counted but not stored; 0 = stored with error tags.
- p_err_cnt_width, 8, width of the saturating errored-frame counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- rx_data_i  in  8  received byte from the receiver; stable while rx_busy_i=0.
- rx_busy_i  in  1  receiver frame in progress.
- rx_parity_err_i  in  1  receiver parity error flag; may clear before rx_busy_i falls.
- rx_framing_err_i  in  1  receiver framing error flag; may clear before rx_busy_i falls.
- clear_i  in  1  synchronous flush of FIFO, counter and overrun.
- m_data_o  out  8  head-entry byte.
- m_parity_err_o  out  1  head-entry parity tag.
- m_framing_err_o  out  1  head-entry framing tag.
- m_valid_o  out  1  head entry available.
- m_ready_i  in  1  consumer accepts the head entry.
- level_o  out  $clog2(p_depth)+1  current occupancy, 0..p_depth.
- full_o  out  1  level_o == p_depth.
- empty_o  out  1  level_o == 0.
- overrun_o  out  1  sticky: a frame was lost because the FIFO was full.
- overrun_clr_i  in  1  clears overrun_o.
- err_cnt_o  out  p_err_cnt_width  saturating count of errored frames.

Behaviour:
- Reset values: level_o=0, empty_o=1, full_o=0, m_valid_o=0, overrun_o=0, err_cnt_o=0, pointers=0, busy_q=0, armed=0, error accumulators=0.
  - m_data_o and the tags are don't-care while m_valid_o=0.
- Arming:
  - armed sets on the first cycle rx_busy_i=0 is sampled.
  - A frame already in progress when reset deasserts is therefore never pushed.
- Frame end:
  - busy_q is rx_busy_i registered.
  - frame_end is cycle N with busy_q=1, rx_busy_i=0 and armed=1.
- Error accumulation:
  - acc_par sets on any cycle with rx_parity_err_i=1 and (rx_busy_i or busy_q); acc_frm likewise for rx_framing_err_i.
  - Both clear at the end of the frame_end cycle.
  - Entry tags are (acc or live input) sampled in cycle N.
- Push:
  - In cycle N, entry {framing tag, parity tag, rx_data_i} is written at the closing edge, unless suppressed by p_drop_errored=1 with either tag set.
  - m_valid_o=1 from cycle N+1 if the FIFO was empty (latency: one cycle after frame_end).
- Errored frame counting:
  - Each errored frame (either tag set) increments err_cnt_o at the end of cycle N, whether stored or dropped.
  - err_cnt_o saturates at all-ones.
- Pop: m_valid_o & m_ready_i at an edge advances rd_ptr and decrements level. m_ready_i while m_valid_o=0 is ignored.
- Output path:
  - m_data_o and the tags come from mem[rd_ptr] (register array, combinational read).
  - m_valid_o = !empty_o.
- Pointers: $clog2(p_depth) bits each, wrap modulo p_depth; level_o is tracked explicitly.
- Full, push with no pop: entry discarded, overrun_o sets, level unchanged. err_cnt_o still counts if the entry was errored.
- Full, push and pop in the same cycle: both happen, level stays p_depth, no overrun.
- Push and pop in the same cycle otherwise: level unchanged, both pointers advance.
- overrun_o clear: cleared by overrun_clr_i or clear_i. A new overrun in the same cycle wins (stays 1).
- clear_i:
  - Next cycle: pointers=0, level=0, m_valid_o=0, err_cnt_o=0, overrun_o=0.
  - A frame_end coinciding with clear_i is discarded and not counted; its accumulators still clear.
  - clear_i does not affect armed or busy_q.
- Async reset mid-operation: immediate return to reset values, contents discarded.

Test Plan:
- Single frame 0xA5, no errors; rx_busy_i falls in cycle N -> cycle N+1: m_valid_o=1, m_data_o=0xA5, tags 0, level_o=1. Pop with m_ready_i=1 -> empty_o=1.
- Parity flag pulses 1 cycle mid-frame and clears before busy falls, byte 0x3C, p_drop_errored=0 -> entry 0x3C with m_parity_err_o=1, err_cnt_o=1. Same with p_drop_errored=1 -> FIFO stays empty, err_cnt_o=1.
- 17 frames 0x00..0x10 with m_ready_i=0, p_depth=16 -> full_o=1, level_o=16, overrun_o=1; drained data = 0x00..0x0F in order. overrun_clr_i -> overrun_o=0.
- FIFO full, frame_end in the same cycle as a pop -> level_o stays 16, overrun_o stays 0, newest byte is last out.
- rst_n_i deasserted while rx_busy_i=1, busy then falls -> nothing pushed; the next complete frame 0x55 is pushed normally.
- 300 framing-errored frames with p_err_cnt_width=8 -> err_cnt_o=255. clear_i -> err_cnt_o=0, level_o=0, m_valid_o=0 the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind a UART receiver core.
// Finds the end of each frame from the receiver's busy flag and tags the byte
// with the parity/framing errors seen during that frame. Tagged bytes go into a
// FIFO that drains over a valid/ready stream. Overrun is a sticky flag and
// errored frames are counted in a saturating counter.
module uart_rx_fifo #(
  parameter int p_depth         = 16,
  parameter int p_drop_errored  = 0,
  parameter int p_err_cnt_width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_busy_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_framing_err_i,
  input  logic                       clear_i,
  output logic [7:0]                 m_data_o,
  output logic                       m_parity_err_o,
  output logic                       m_framing_err_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(p_depth):0]   level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overrun_o,
  input  logic                       overrun_clr_i,
  output logic [p_err_cnt_width-1:0] err_cnt_o
);

  localparam int aw = $clog2(p_depth);
  localparam int lw = aw + 1;
  localparam logic [lw-1:0]              lvl_full = lw'(p_depth);
  localparam logic [lw-1:0]              lvl_one  = lw'(1);
  localparam logic [aw-1:0]              ptr_one  = aw'(1);
  localparam logic [p_err_cnt_width-1:0] cnt_one  = p_err_cnt_width'(1);
  localparam logic                       drop_errored = (p_drop_errored != 0);

  typedef struct packed {
    logic       frm;
    logic       par;
    logic [7:0] data;
  } entry_t;

  // Frame tracking
  logic busy_q;
  logic armed;
  logic acc_par;
  logic acc_frm;

  // FIFO state
  entry_t                     mem [p_depth];
  logic [aw-1:0]              wr_ptr;
  logic [aw-1:0]              rd_ptr;
  logic [lw-1:0]              level;
  logic                       overrun;
  logic [p_err_cnt_width-1:0] err_cnt;

  // Per-cycle decisions
  logic   in_frame;
  logic   frame_end;
  logic   tag_par;
  logic   tag_frm;
  logic   errored;
  logic   push;
  logic   pop;
  logic   overrun_set;
  entry_t head;

  // A frame spans its busy cycles plus the cycle in which busy drops.
  assign in_frame  = rx_busy_i | busy_q;
  assign frame_end = busy_q & ~rx_busy_i & armed;
  // Error flags may drop before busy does, so the tag merges history and live value.
  assign tag_par   = acc_par | rx_parity_err_i;
  assign tag_frm   = acc_frm | rx_framing_err_i;
  assign errored   = tag_par | tag_frm;

  // Busy edge detection, arming after reset, and per-frame error accumulation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q  <= 1'b0;
      armed   <= 1'b0;
      acc_par <= 1'b0;
      acc_frm <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in the design samples the values from before this edge.
      busy_q <= rx_busy_i;
      if (!rx_busy_i) armed <= 1'b1;
      if (frame_end) begin
        acc_par <= 1'b0;
        acc_frm <= 1'b0;
      end else if (in_frame) begin
        acc_par <= acc_par | rx_parity_err_i;
        acc_frm <= acc_frm | rx_framing_err_i;
      end
    end
  end

  // Decide whether the closing frame is stored, dropped, or lost to overrun.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    push        = 1'b0;
    overrun_set = 1'b0;
    pop         = m_valid_o & m_ready_i;
    if (frame_end && !clear_i && !(drop_errored && errored)) begin
      if (!full_o || pop) push = 1'b1;
      else                overrun_set = 1'b1;
    end
  end

  // Pointers, occupancy, sticky overrun and errored-frame counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
      err_cnt <= '0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
      if (push && !pop)      level <= level + lvl_one;
      else if (pop && !push) level <= level - lvl_one;
      overrun <= overrun_set | (overrun & ~overrun_clr_i);
      if (frame_end && errored && !(&err_cnt)) err_cnt <= err_cnt + cnt_one;
    end
  end

  // Entry storage, written at the edge that closes the frame.
  // NOTE: the array has no reset; entries are only observed through rd_ptr
  // while level is non-zero, and the pointers themselves are reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{frm: tag_frm, par: tag_par, data: rx_data_i};
  end

  assign head            = mem[rd_ptr];
  assign m_data_o        = head.data;
  assign m_parity_err_o  = head.par;
  assign m_framing_err_o = head.frm;
  assign level_o         = level;
  assign full_o          = (level == lvl_full);
  assign empty_o         = (level == '0);
  assign m_valid_o       = ~empty_o;
  assign overrun_o       = overrun;
  assign err_cnt_o       = err_cnt;

endmodule
